// File: rtl/ls_pkg.sv
// ---------------------------------------------------------------------------
// ls_pkg
// Shared definitions for the load/store sequencer:
//   - memory op codes (LW/LH/LB/SW/SH/SB) and access-size decode
//   - FSM state encoding
//   - MEM_LAT legality check and alignment/legality helper
// ---------------------------------------------------------------------------
package ls_pkg;

  localparam logic [2:0] OP_LW = 3'b000;
  localparam logic [2:0] OP_LH = 3'b001;
  localparam logic [2:0] OP_LB = 3'b010;
  localparam logic [2:0] OP_SW = 3'b100;
  localparam logic [2:0] OP_SH = 3'b101;
  localparam logic [2:0] OP_SB = 3'b110;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 7;

  // op[1:0] encodes the access width for every legal op; op[2] marks a store.
  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10,
    SZ_BAD  = 2'b11
  } ls_size_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } ls_state_e;

  function automatic logic mem_lat_ok(input int lat);
    return (lat >= MEM_LAT_MIN) && (lat <= MEM_LAT_MAX);
  endfunction

  function automatic ls_size_e op_size(input logic [2:0] op);
    return ls_size_e'(op[1:0]);
  endfunction

  // True for illegal op codes and for halfword/word accesses that are not
  // naturally aligned within the word.
  function automatic logic op_is_bad(input logic [2:0] op, input logic [1:0] off);
    logic bad;
    case (op)
      OP_LW, OP_SW: bad = (off != 2'b00);
      OP_LH, OP_SH: bad = off[0];
      OP_LB, OP_SB: bad = 1'b0;
      default:      bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ls_lane_mux.sv
// ---------------------------------------------------------------------------
// ls_lane_mux
// Purely combinational little-endian lane steering.
//   Extract: pick byte/half/word of rd_word_i at off_i, zero-extended.
//   Merge:   overlay the low byte/half of st_data_i onto old_word_i at off_i
//            (a word op replaces all four lanes).
// Ports:
//   op_i         [2:0]  op code (width taken from op[1:0])
//   off_i        [1:0]  byte offset within the word
//   rd_word_i    [31:0] word to extract from
//   old_word_i   [31:0] word read back for read-modify-write
//   st_data_i    [31:0] store source register
//   ext_word_o   [31:0] zero-extended extracted value
//   merge_word_o [31:0] merged store word
// ---------------------------------------------------------------------------
module ls_lane_mux
  import ls_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] rd_word_i,
  input  logic [31:0] old_word_i,
  input  logic [31:0] st_data_i,
  output logic [31:0] ext_word_o,
  output logic [31:0] merge_word_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [3:0]  lane_en;
  logic [31:0] st_repl;

  assign byte_sel = rd_word_i[{off_i, 3'b000} +: 8];
  assign half_sel = off_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];

  always_comb begin
    ext_word_o = rd_word_i;
    lane_en    = 4'b1111;
    st_repl    = st_data_i;
    case (op_size(op_i))
      SZ_BYTE: begin
        ext_word_o = {24'h000000, byte_sel};
        lane_en    = 4'b0001 << off_i;
        // Replicate so that every lane offers the store byte; lane_en picks one.
        st_repl    = {4{st_data_i[7:0]}};
      end
      SZ_HALF: begin
        ext_word_o = {16'h0000, half_sel};
        lane_en    = off_i[1] ? 4'b1100 : 4'b0011;
        st_repl    = {2{st_data_i[15:0]}};
      end
      default: begin
        ext_word_o = rd_word_i;
        lane_en    = 4'b1111;
        st_repl    = st_data_i;
      end
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign merge_word_o[8*gi +: 8] = lane_en[gi] ? st_repl[8*gi +: 8]
                                                 : old_word_i[8*gi +: 8];
  end

endmodule

// File: rtl/load_store_ctrl.sv
// ---------------------------------------------------------------------------
// load_store_ctrl
// Multicycle sequencer for LW/LH/LB/SW/SH/SB against a word-wide memory with
// MEM_LAT cycles of read latency. Sub-word stores are done as
// read-modify-write. Also drives the byte input/selector of the sign
// extender so its output matches load_data for LB.
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   start      one-cycle request, only honoured in IDLE
//   op [2:0]   LW=000 LH=001 LB=010 SW=100 SH=101 SB=110
//   addr       byte address
//   rt_data    store source
//   mem_rdata  memory read word (valid MEM_LAT cycles after mem_addr)
//   mem_addr   word-aligned memory address
//   mem_wr     one-cycle write strobe per store
//   mem_wdata  write word (merged for SB/SH), 0 when not writing
//   ext_sel    1 = extender takes the MDR byte path
//   ext_byte   byte lane for the extender
//   load_data  load result, held until the next load completes
//   load_we    register-file write enable, one cycle, loads only
//   busy       high whenever not IDLE
//   done       one-cycle completion pulse (also on error)
//   misalign   one-cycle error pulse, coincident with done
// ---------------------------------------------------------------------------
module load_store_ctrl
  import ls_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] rt_data,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  output logic        ext_sel,
  output logic [7:0]  ext_byte,
  output logic [31:0] load_data,
  output logic        load_we,
  output logic        busy,
  output logic        done,
  output logic        misalign
);

  if (!mem_lat_ok(MEM_LAT)) begin : g_bad_lat
    $error("load_store_ctrl: MEM_LAT must be in 1..7");
  end

  // RD lasts MEM_LAT cycles: counter loads MEM_LAT-1 and leaves RD at zero.
  localparam logic [2:0] LAT_RELOAD = 3'(MEM_LAT - 1);

  ls_state_e   state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] rd_q, rd_d;
  logic [31:0] mdr_q, mdr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] load_q, load_d;

  logic [31:0] mux_word;
  logic [31:0] ext_word;
  logic [31:0] merge_word;

  // In CAP the word is still on the memory bus; afterwards it lives in mdr_q.
  assign mux_word = (state_q == ST_CAP) ? mem_rdata : mdr_q;

  ls_lane_mux u_lane_mux (
    .op_i         (op_q),
    .off_i        (addr_q[1:0]),
    .rd_word_i    (mux_word),
    .old_word_i   (mdr_q),
    .st_data_i    (rd_q),
    .ext_word_o   (ext_word),
    .merge_word_o (merge_word)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      op_q    <= 3'b000;
      addr_q  <= 32'h0;
      rd_q    <= 32'h0;
      mdr_q   <= 32'h0;
      cnt_q   <= 3'd0;
      load_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      mdr_q   <= mdr_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    mdr_d   = mdr_q;
    cnt_d   = cnt_q;
    load_d  = load_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d   = op;
          addr_d = addr;
          rd_d   = rt_data;
          if (op_is_bad(op, addr[1:0])) begin
            state_d = ST_ERR;
          end else if (op == OP_SW) begin
            // Full-word store needs no read-back.
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
            cnt_d   = LAT_RELOAD;
          end
        end
      end
      ST_RD: begin
        if (cnt_q == 3'd0) begin
          state_d = ST_CAP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_CAP: begin
        mdr_d = mem_rdata;
        if (op_q[2]) begin
          state_d = ST_WR;
        end else begin
          load_d  = ext_word;
          state_d = ST_DONE;
        end
      end
      ST_WR:   state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_addr  = {addr_q[31:2], 2'b00};
    mem_wr    = (state_q == ST_WR);
    mem_wdata = (state_q == ST_WR) ? merge_word : 32'h0;
    load_data = load_q;
    load_we   = (state_q == ST_DONE) && !op_q[2];
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE) || (state_q == ST_ERR);
    misalign  = (state_q == ST_ERR);
    ext_sel   = (op_q == OP_LB) && ((state_q == ST_CAP) || (state_q == ST_DONE));
    ext_byte  = ext_sel ? ext_word[7:0] : 8'h00;
  end

endmodule
